// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, FSM states and
// indices into the 18-bit micro-control vector.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_EXEC     = 3'd2,
      S_MUL_STEP = 3'd3,
      S_DIV_STEP = 3'd4,
      S_DIV_CORR = 3'd5,
      S_DONE     = 3'd6
   } state_e;

   localparam int CTRL_W    = 18;
   localparam int C_LOAD    = 0;
   localparam int C_LOAD_M  = 1;
   localparam int C_ADD_M   = 2;
   localparam int C_SUB_M   = 3;
   localparam int C_ASR     = 4;
   localparam int C_SHL     = 5;
   localparam int C_Q1      = 6;
   localparam int C_Q0      = 7;
   localparam int C_CNT     = 8;
   localparam int C_CORR    = 9;
   localparam int C_OUT_AQ  = 10;
   localparam int C_OUT_ONE = 11;
   localparam int C_SEL_AND = 12;
   localparam int C_SEL_OR  = 13;
   localparam int C_SEL_XOR = 14;
   localparam int C_SEL_ADD = 15;
   localparam int C_SEL_SUB = 16;
   localparam int C_END     = 17;

endpackage

// File: rtl/alu_addsub.sv
// 9-bit adder/subtractor shared by the Booth steps, the non-restoring
// division steps, the remainder correction and single-cycle ADD/SUB.
module alu_addsub (
   input  logic [8:0] a_i,
   input  logic [8:0] b_i,
   input  logic       sub_i,
   output logic [8:0] sum_o
);

   assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/alu.sv
// Multi-cycle 8-bit ALU: single-cycle logic/ADD/SUB, radix-2 Booth MUL and
// non-restoring DIV, sequenced by a micro-control vector decoded from the FSM.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [7:0]        X,
   input  logic [7:0]        Y,
   input  logic [7:0]        A_divide,
   input  logic [2:0]        op,
   input  logic              BEGIN,
   output logic [15:0]       OUT,
   output logic              END,
   output logic [7:0]        A,
   output logic [7:0]        Q,
   output logic [7:0]        m,
   output logic [7:0]        sum_out,
   output logic [2:0]        count,
   output logic              ovr,
   output logic              q8,
   output logic              r,
   output logic [CTRL_W-1:0] control,
   output state_e            state_o
);

   state_e            state_q, state_d;
   logic [7:0]        a_q, q_q, m_q;
   logic              q8_q, r_q, ovr_q, end_q, dovf_q;
   logic [2:0]        count_q, op_q;
   logic [15:0]       out_q;
   logic [CTRL_W-1:0] ctrl;
   logic [8:0]        add_a, add_b, add_sum;
   logic              add_sub;
   logic [1:0]        booth;
   logic [15:0]       one_res;
   logic              one_ovr;

   assign booth = {q_q[0], q8_q};

   always_ff @(posedge clk) begin
      if (resetn) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (BEGIN) state_d = S_LOAD;
         S_LOAD: begin
            if (op == OP_MUL)      state_d = S_MUL_STEP;
            else if (op == OP_DIV) state_d = S_DIV_STEP;
            else                   state_d = S_EXEC;
         end
         S_EXEC:     state_d = S_DONE;
         S_MUL_STEP: if (count_q == 3'd7) state_d = S_DONE;
         S_DIV_STEP: if (count_q == 3'd7) state_d = S_DIV_CORR;
         S_DIV_CORR: state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Adder operand steering; IDLE drives zeros so sum_out rests at 0.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      unique case (state_q)
         S_EXEC: begin
            add_a   = {q_q[7], q_q};
            add_b   = {m_q[7], m_q};
            add_sub = (op_q == OP_SUB);
         end
         S_MUL_STEP: begin
            add_a   = {a_q[7], a_q};
            add_b   = (booth == 2'b01 || booth == 2'b10) ? {m_q[7], m_q} : 9'd0;
            add_sub = (booth == 2'b10);
         end
         S_DIV_STEP: begin
            add_a   = {a_q, q_q[7]};
            add_b   = {1'b0, m_q};
            add_sub = ~r_q;
         end
         S_DIV_CORR: begin
            add_a = {r_q, a_q};
            add_b = r_q ? {1'b0, m_q} : 9'd0;
         end
         default: ;
      endcase
   end

   alu_addsub u_addsub (
      .a_i   (add_a),
      .b_i   (add_b),
      .sub_i (add_sub),
      .sum_o (add_sum)
   );

   always_comb begin
      one_res = '0;
      one_ovr = 1'b0;
      unique case (op_q)
         OP_AND: one_res = {8'h00, q_q & m_q};
         OP_OR:  one_res = {8'h00, q_q | m_q};
         OP_XOR: one_res = {8'h00, q_q ^ m_q};
         OP_ADD, OP_SUB: begin
            one_res = {{8{add_sum[7]}}, add_sum[7:0]};
            one_ovr = add_sum[8] ^ add_sum[7];
         end
         OP_DIV: begin
            one_res = 16'hFFFF;
            one_ovr = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ctrl = '0;
      unique case (state_q)
         S_LOAD: begin
            ctrl[C_LOAD]   = 1'b1;
            ctrl[C_LOAD_M] = 1'b1;
         end
         S_EXEC: begin
            ctrl[C_OUT_ONE] = 1'b1;
            ctrl[C_SEL_AND] = (op_q == OP_AND);
            ctrl[C_SEL_OR]  = (op_q == OP_OR);
            ctrl[C_SEL_XOR] = (op_q == OP_XOR);
            ctrl[C_SEL_ADD] = (op_q == OP_ADD);
            ctrl[C_SEL_SUB] = (op_q == OP_SUB);
         end
         S_MUL_STEP: begin
            ctrl[C_ASR]   = 1'b1;
            ctrl[C_CNT]   = 1'b1;
            ctrl[C_ADD_M] = (booth == 2'b01);
            ctrl[C_SUB_M] = (booth == 2'b10);
         end
         S_DIV_STEP: begin
            ctrl[C_CNT] = 1'b1;
            // An out-of-range divide only counts through the steps.
            if (!dovf_q) begin
               ctrl[C_SHL]   = 1'b1;
               ctrl[C_ADD_M] = r_q;
               ctrl[C_SUB_M] = ~r_q;
               ctrl[C_Q1]    = ~add_sum[8];
               ctrl[C_Q0]    = add_sum[8];
            end
         end
         S_DIV_CORR: ctrl[C_CORR] = r_q & ~dovf_q;
         S_DONE: begin
            ctrl[C_END] = 1'b1;
            if (op_q == OP_MUL || (op_q == OP_DIV && !dovf_q)) ctrl[C_OUT_AQ] = 1'b1;
            else if (op_q == OP_DIV)                            ctrl[C_OUT_ONE] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         q8_q    <= 1'b0;
         r_q     <= 1'b0;
         count_q <= '0;
         op_q    <= '0;
         dovf_q  <= 1'b0;
         out_q   <= '0;
         ovr_q   <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         end_q <= ctrl[C_END];
         if (ctrl[C_LOAD]) begin
            a_q     <= (op == OP_DIV) ? A_divide : 8'h00;
            q_q     <= X;
            q8_q    <= 1'b0;
            r_q     <= 1'b0;
            count_q <= '0;
            op_q    <= op;
            dovf_q  <= (op == OP_DIV) && ((Y == 8'h00) || (A_divide >= Y));
         end
         if (ctrl[C_LOAD_M]) m_q <= Y;
         if (ctrl[C_ASR]) begin
            a_q  <= add_sum[8:1];
            q_q  <= {add_sum[0], q_q[7:1]};
            q8_q <= q_q[0];
         end
         if (ctrl[C_SHL]) begin
            {r_q, a_q} <= add_sum;
            q_q        <= {q_q[6:0], ctrl[C_Q1]};
         end
         if (ctrl[C_CORR]) {r_q, a_q} <= add_sum;
         if (ctrl[C_CNT])  count_q <= count_q + 3'd1;
         if (ctrl[C_OUT_AQ]) begin
            out_q <= {a_q, q_q};
            ovr_q <= 1'b0;
         end
         if (ctrl[C_OUT_ONE]) begin
            out_q <= one_res;
            ovr_q <= one_ovr;
         end
      end
   end

   assign OUT     = out_q;
   assign END     = end_q;
   assign A       = a_q;
   assign Q       = q_q;
   assign m       = m_q;
   assign sum_out = add_sum[7:0];
   assign count   = count_q;
   assign ovr     = ovr_q;
   assign q8      = q8_q;
   assign r       = r_q;
   assign control = ctrl;
   assign state_o = state_q;

endmodule

// File: tb/tb_alu.sv
// Bench for the multi-cycle ALU: directed vectors plus random operations
// checked against an arithmetic reference model.
module tb_alu;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [7:0]  X = '0, Y = '0, A_divide = '0;
   logic [2:0]  op = '0;
   logic        BEGIN = 1'b0;
   logic [15:0] OUT;
   logic        END;
   logic [7:0]  A, Q, m, sum_out;
   logic [2:0]  count;
   logic        ovr, q8, r;
   logic [17:0] control;
   alu_pkg::state_e state_dbg;

   int total = 0;
   int bad   = 0;
   logic [16:0] exp_q[$];

   alu dut (
      .clk(clk), .resetn(resetn), .X(X), .Y(Y), .A_divide(A_divide), .op(op),
      .BEGIN(BEGIN), .OUT(OUT), .END(END), .A(A), .Q(Q), .m(m), .sum_out(sum_out),
      .count(count), .ovr(ovr), .q8(q8), .r(r), .control(control), .state_o(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: results straight from integer arithmetic on the operands.
   task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] ad, output logic [15:0] eo, output logic eov,
                        output int en);
      int sx, sy, s, dd, qq, rr;
      logic [7:0] s8;
      sx = $signed(x);
      sy = $signed(y);
      eo = '0; eov = 1'b0; en = 3;
      case (o)
         3'd0: eo = {8'h00, x & y};
         3'd1: eo = {8'h00, x | y};
         3'd2: eo = {8'h00, x ^ y};
         3'd3, 3'd4: begin
            s   = (o == 3'd3) ? sx + sy : sx - sy;
            s8  = s[7:0];
            eo  = {{8{s8[7]}}, s8};
            eov = (s > 127) || (s < -128);
         end
         3'd5: begin
            s  = sx * sy;
            eo = s[15:0];
            en = 10;
         end
         3'd6: begin
            en = 11;
            if (y == 8'd0 || ad >= y) begin
               eo = 16'hFFFF; eov = 1'b1;
            end else begin
               dd = {16'd0, ad, x};
               qq = dd / int'(y);
               rr = dd % int'(y);
               eo = {rr[7:0], qq[7:0]};
            end
         end
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] ad, input bit poke, output logic [15:0] got);
      logic [15:0] eo;
      logic        eov;
      int          en, n;
      logic [16:0] e;
      model(o, x, y, ad, eo, eov, en);
      exp_q.push_back({eov, eo});
      @(negedge clk);
      op = o; X = x; Y = y; A_divide = ad; BEGIN = 1'b1;
      @(posedge clk);
      @(negedge clk);
      BEGIN = 1'b0;
      @(posedge clk);
      #1;
      n = 1;
      // Operands are captured now; scramble the inputs to prove they are held.
      X = 8'($urandom); Y = 8'($urandom); A_divide = 8'($urandom); op = 3'($urandom);
      while (!END && n < 40) begin
         if (poke && n == 4) BEGIN = 1'b1;
         if (poke && n == 5) BEGIN = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      BEGIN = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("lat op%0d", o), n, en);
      chk($sformatf("out op%0d x%0h y%0h a%0h", o, x, y, ad), OUT, e[15:0]);
      chk($sformatf("ovr op%0d", o), ovr, e[16]);
      got = OUT;
      @(posedge clk);
      #1;
      chk("end_width", END, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out"}, OUT, 0);
      chk({tag, "_aqm"}, {A, Q, m, sum_out}, 0);
      chk({tag, "_misc"}, {count, ovr, q8, r, END}, 0);
      chk({tag, "_ctrl"}, control, 0);
   endtask

   initial begin
      logic [15:0] got;
      logic [2:0]  o;
      logic [7:0]  x, y, ad;
      bit          saw_end;

      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      resetn = 1'b0;

      run_op(3'd6, 8'h8B, 8'h87, 8'h16, 1'b0, got); chk("div_5771", got, 16'h652A);
      run_op(3'd6, 8'h99, 8'h53, 8'h1C, 1'b0, got); chk("div_7321", got, 16'h1158);
      run_op(3'd6, 8'h42, 8'h00, 8'h00, 1'b0, got); chk("div_y0", {ovr, got}, 17'h1FFFF);
      run_op(3'd6, 8'h00, 8'h10, 8'h10, 1'b0, got); chk("div_ad_eq_y", {ovr, got}, 17'h1FFFF);
      run_op(3'd5, 8'hB9, 8'h85, 8'h00, 1'b0, got); chk("mul_neg", got, 16'h221D);
      run_op(3'd5, 8'h80, 8'h80, 8'h00, 1'b0, got); chk("mul_min", got, 16'h4000);
      run_op(3'd0, 8'h11, 8'h05, 8'h00, 1'b0, got); chk("and", got, 16'h0001);
      run_op(3'd1, 8'h11, 8'h05, 8'h00, 1'b0, got); chk("or", got, 16'h0015);
      run_op(3'd2, 8'h11, 8'h05, 8'h00, 1'b0, got); chk("xor", got, 16'h0014);
      run_op(3'd3, 8'h11, 8'h05, 8'h00, 1'b0, got); chk("add", got, 16'h0016);
      run_op(3'd4, 8'h11, 8'h05, 8'h00, 1'b0, got); chk("sub", got, 16'h000C);
      run_op(3'd3, 8'h7F, 8'h01, 8'h00, 1'b0, got); chk("add_ovf", {ovr, got}, 17'h1FF80);
      run_op(3'd4, 8'h80, 8'h01, 8'h00, 1'b0, got); chk("sub_ovf", {ovr, got}, 17'h1007F);
      run_op(3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, got); chk("rsv", {ovr, got}, 17'h00000);
      run_op(3'd5, 8'hB9, 8'h85, 8'h00, 1'b1, got); chk("mul_poked", got, 16'h221D);

      // Reset in the middle of a divide.
      @(negedge clk);
      op = 3'd6; X = 8'h8B; Y = 8'h87; A_divide = 8'h16; BEGIN = 1'b1;
      @(negedge clk);
      BEGIN = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("mid_div_reset");
      @(negedge clk);
      resetn = 1'b0;
      saw_end = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (END) saw_end = 1'b1;
      end
      chk("no_end_after_abort", saw_end, 1'b0);
      run_op(3'd6, 8'h8B, 8'h87, 8'h16, 1'b0, got); chk("div_after_reset", got, 16'h652A);

      for (int i = 0; i < 40; i++) begin
         o  = 3'($urandom_range(0, 7));
         x  = 8'($urandom);
         y  = 8'($urandom);
         ad = 8'($urandom);
         if (o == 3'd6 && i % 4 != 0 && y != 8'd0) ad = 8'($urandom_range(0, int'(y) - 1));
         run_op(o, x, y, ad, 1'b0, got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetn  in  1  synchronous active-high reset (1 = reset), despite the name.
REQ-004 X  in  8  operand 1; also the dividend low byte for DIV.
REQ-005 Y  in  8  operand 2; also the divisor for DIV.
REQ-006 A_divide  in  8  dividend high byte for DIV; ignored otherwise.
REQ-007 op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL (signed), 110 DIV (unsigned), 111 reserved.
REQ-008 BEGIN  in  1  start strobe, sampled only in IDLE.
REQ-009 OUT  out  16  result register.
REQ-010 END  out  1  one-cycle done pulse.
REQ-011 A, Q, m, sum_out  out  8 each  debug views of the accumulator, multiplier/quotient and divisor registers, and the low byte of the adder output.
REQ-012 count  out  3  iteration counter.
REQ-013 ovr, q8, r  out  1 each  overflow flag, Booth Q[-1] bit, and partial-remainder sign bit (A bit 8).
REQ-014 control  out  18  active micro-control vector:
- c0 load operands; c1 load M<-Y; c2 A<-A+M; c3 A<-A-M.
- c4 arithmetic right shift {A,Q,q8}; c5 left shift {r,A,Q}.
- c6 Q[0]<-1; c7 Q[0]<-0; c8 count+1; c9 remainder correction.
- c10 OUT<-{A,Q}; c11 OUT<-single-cycle result; c12..c16 select AND/OR/XOR/ADD/SUB; c17 END.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, EXEC, MUL_STEP, DIV_STEP, DIV_CORR and DONE.
REQ-016 FSM transitions:
- IDLE->LOAD on BEGIN=1.
- LOAD->EXEC for op 0xx/100/111, ->MUL_STEP for 101, ->DIV_STEP for 110.
- DONE->IDLE unconditionally.
REQ-017 Operands X, Y, A_divide and op SHALL be captured in LOAD (the cycle after BEGIN is sampled) and held internally until DONE.
REQ-018 Latency (END high n edges after the edge that samples BEGIN), END high exactly one cycle:
- logic/ADD/SUB/reserved: n=3.
- MUL: n=10.
- DIV: n=11.
REQ-019 BEGIN SHALL be ignored outside IDLE; OUT and ovr SHALL hold their values until the next LOAD.
REQ-020 Logic ops SHALL set OUT={8'h00, X op Y} and ovr=0.
REQ-021 ADD/SUB SHALL set OUT to the 8-bit two's-complement result sign-extended to 16 bits, and ovr to signed overflow.
REQ-022 Reserved op 111 SHALL set OUT=0 and ovr=0.
REQ-023 MUL SHALL use radix-2 Booth:
- LOAD sets A=0, Q=X, q8=0, M=Y, count=0.
- Each MUL_STEP computes sum_out = A+M if {Q[0],q8}=01, A-M if 10, else A, then arithmetic-right-shifts {sum,Q,q8} in the same cycle.
- After the step with count=7, OUT={A,Q} (signed 16-bit product) and ovr=0.
REQ-024 DIV SHALL use non-restoring division with a 9-bit partial remainder {r,A}:
- LOAD sets {r,A}={0,A_divide}, Q=X, M=Y.
- Each DIV_STEP left-shifts {r,A,Q}, subtracts M if the prior r=0 or adds M if r=1, and sets Q[0]=~new r.
- 8 steps, then DIV_CORR adds M if r=1.
- OUT={remainder A, quotient Q}.
REQ-025 If Y=0 or A_divide>=Y, DIV SHALL skip the steps, set ovr=1 and OUT=16'hFFFF, and still complete with n=11.

Reset
REQ-026 While resetn=1 at a clock edge, the FSM SHALL enter IDLE and OUT, A, Q, m, sum_out, count, ovr, q8, r, END and control SHALL all be 0.
REQ-027 Reset mid-operation SHALL abort the operation without asserting END; the next BEGIN SHALL start a fresh operation.

Structure
REQ-028 Opcode encodings, FSM state encodings and control-bit indices SHALL live in a shared package alu_pkg.
REQ-029 The datapath (9-bit add/sub adder driving sum_out) SHALL be one sub-module alu_addsub; the FSM and registers SHALL stay in alu.

Verification
REQ-030 DIV with A_divide=0x16, X=0x8B, Y=0x87 (5771/135) -> OUT=0x652A (R 101, Q 42), ovr=0, END at n=11.
REQ-031 DIV with A_divide=0x1C, X=0x99, Y=0x53 (7321/83) -> OUT=0x1158 (R 17, Q 88); DIV with Y=0 -> OUT=0xFFFF, ovr=1.
REQ-032 MUL with X=0xB9 (-71), Y=0x85 (-123) -> OUT=0x221D (8733) at n=10; MUL with X=0x80, Y=0x80 -> OUT=0x4000.
REQ-033 X=0x11, Y=0x05 -> AND 0x0001, OR 0x0015, XOR 0x0014, ADD 0x0016, SUB 0x000C, each END at n=3.
REQ-034 ADD with X=0x7F, Y=0x01 -> OUT=0xFF80, ovr=1; BEGIN pulsed mid-MUL -> ignored, product unchanged.
REQ-035 Reset asserted mid-DIV -> all outputs 0 next cycle, no END; a new BEGIN afterwards completes correctly.
